// File: rtl/lval_pkg.sv
// Shared constants, FSM encoding and FIFO entry layout for the line packer.
package lval_pkg;

    localparam int unsigned DEF_LINE_PIXELS  = 256;
    localparam int unsigned DEF_PIX_PER_WORD = 4;
    localparam int unsigned DEF_FIFO_DEPTH   = 16;
    localparam int unsigned PIX_W            = 12;
    localparam int unsigned WORD_W           = 64;
    localparam int unsigned ENTRY_W          = WORD_W + 3;

    localparam logic [1:0] ST_PACK = 2'd0;
    localparam logic [1:0] ST_DROP = 2'd1;
    localparam logic [1:0] ST_TERM = 2'd2;

    typedef struct packed {
        logic              err;
        logic              last;
        logic              first;
        logic [WORD_W-1:0] data;
    } entry_t;

    function automatic logic [WORD_W-1:0] pack_pixels(
        input logic [PIX_W-1:0] p3,
        input logic [PIX_W-1:0] p2,
        input logic [PIX_W-1:0] p1,
        input logic [PIX_W-1:0] p0
    );
        return {4'b0, p3, 4'b0, p2, 4'b0, p1, 4'b0, p0};
    endfunction

endpackage

// File: rtl/lval_sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; a pop frees space for a same-cycle push.
module lval_sync_fifo_fwft #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 67
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_wr;
    logic             do_rd;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    // Head entry is zeroed while empty so downstream sees clean outputs after reset.
    assign rd_data = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_wr) begin
                wptr <= wptr + 1'b1;
            end
            if (do_rd) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/lval_line_packer.sv
// Packs 12-bit pixels four to a 64-bit word, frames lines first/last into a FWFT FIFO,
// and replaces the tail of any overflowed line with a single error terminator.
module lval_line_packer
    import lval_pkg::*;
#(
    parameter int unsigned LINE_PIXELS  = DEF_LINE_PIXELS,
    parameter int unsigned PIX_PER_WORD = DEF_PIX_PER_WORD,
    parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic              clk_rxg,
    input  logic              rst_rx_n,
    input  logic              sync_valid,
    input  logic [PIX_W-1:0]  sync_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [WORD_W-1:0] m_data,
    output logic              m_first,
    output logic              m_last,
    output logic              m_err,
    output logic              line_done,
    output logic [15:0]       line_cnt,
    output logic [15:0]       drop_cnt,
    output logic              ovf_sticky,
    input  logic              sts_clr
);

    localparam int unsigned       CNT_W     = $clog2(LINE_PIXELS);
    localparam int unsigned       LANE_W    = $clog2(PIX_PER_WORD);
    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(LINE_PIXELS - 1);
    localparam logic [CNT_W-1:0]  FIRST_END = CNT_W'(PIX_PER_WORD - 1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PIX_PER_WORD - 1);

    logic [CNT_W-1:0]  pix_cnt;
    logic              s_acc;
    logic [CNT_W-1:0]  s_idx;
    logic [PIX_W-1:0]  s_pix;
    logic [LANE_W-1:0] lane;
    logic [PIX_W-1:0]  lane_q [PIX_PER_WORD-1];

    logic [1:0] state, state_d;
    logic       next_line, next_line_d;
    logic       next_done, next_done_d;
    logic       word_done, is_last_pix, seen_next, fin_next;
    logic       fifo_room, wr_en, rd_en, full, empty;
    logic       drop_word, line_good, line_term;
    entry_t     wr_entry, rd_entry;

    // Pixels are registered once so the push lands the cycle after the completing pixel.
    always_ff @(posedge clk_rxg or negedge rst_rx_n) begin
        if (!rst_rx_n) begin
            pix_cnt <= '0;
            s_acc   <= 1'b0;
            s_idx   <= '0;
            s_pix   <= '0;
        end else begin
            s_acc <= sync_valid;
            if (sync_valid) begin
                s_idx   <= pix_cnt;
                s_pix   <= sync_data;
                pix_cnt <= (pix_cnt == LAST_IDX) ? '0 : pix_cnt + 1'b1;
            end
        end
    end

    assign lane = s_idx[LANE_W-1:0];

    always_ff @(posedge clk_rxg or negedge rst_rx_n) begin
        if (!rst_rx_n) begin
            for (int unsigned i = 0; i < PIX_PER_WORD - 1; i++) begin
                lane_q[i] <= '0;
            end
        end else if (s_acc) begin
            for (int unsigned i = 0; i < PIX_PER_WORD - 1; i++) begin
                if (lane == LANE_W'(i)) begin
                    lane_q[i] <= s_pix;
                end
            end
        end
    end

    assign word_done   = s_acc && (lane == LAST_LANE);
    assign is_last_pix = (s_idx == LAST_IDX);
    assign m_valid     = !empty;
    assign rd_en       = m_valid && m_ready;
    assign fifo_room   = !full || rd_en;

    // While a terminator waits for space, a new line that starts (or even ends) is tracked
    // so that each truncated line still gets exactly one terminator.
    always_comb begin
        state_d     = state;
        next_line_d = next_line;
        next_done_d = next_done;
        wr_en       = 1'b0;
        wr_entry    = '0;
        drop_word   = 1'b0;
        line_good   = 1'b0;
        line_term   = 1'b0;
        seen_next   = 1'b0;
        fin_next    = 1'b0;
        case (state)
            ST_PACK: begin
                if (word_done) begin
                    if (fifo_room) begin
                        wr_en          = 1'b1;
                        wr_entry.data  = pack_pixels(s_pix, lane_q[2], lane_q[1], lane_q[0]);
                        wr_entry.first = (s_idx == FIRST_END);
                        wr_entry.last  = is_last_pix;
                        line_good      = is_last_pix;
                    end else begin
                        drop_word = 1'b1;
                        state_d   = is_last_pix ? ST_TERM : ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                if (s_acc && is_last_pix) begin
                    state_d = ST_TERM;
                end
            end
            ST_TERM: begin
                seen_next = next_line || s_acc;
                fin_next  = next_done || (s_acc && is_last_pix);
                if (fifo_room) begin
                    wr_en         = 1'b1;
                    wr_entry.err  = 1'b1;
                    wr_entry.last = 1'b1;
                    line_term     = 1'b1;
                    next_line_d   = 1'b0;
                    next_done_d   = 1'b0;
                    state_d       = fin_next ? ST_TERM : (seen_next ? ST_DROP : ST_PACK);
                end else begin
                    next_line_d = seen_next;
                    next_done_d = fin_next;
                end
            end
            default: state_d = ST_PACK;
        endcase
    end

    always_ff @(posedge clk_rxg or negedge rst_rx_n) begin
        if (!rst_rx_n) begin
            state     <= ST_PACK;
            next_line <= 1'b0;
            next_done <= 1'b0;
        end else begin
            state     <= state_d;
            next_line <= next_line_d;
            next_done <= next_done_d;
        end
    end

    always_ff @(posedge clk_rxg or negedge rst_rx_n) begin
        if (!rst_rx_n) begin
            line_cnt   <= '0;
            drop_cnt   <= '0;
            ovf_sticky <= 1'b0;
        end else if (sts_clr) begin
            line_cnt   <= '0;
            drop_cnt   <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            if (line_good) begin
                line_cnt <= line_cnt + 1'b1;
            end
            if (line_term && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            if (drop_word) begin
                ovf_sticky <= 1'b1;
            end
        end
    end

    assign line_done = line_good || line_term;
    assign m_data    = rd_entry.data;
    assign m_first   = rd_entry.first;
    assign m_last    = rd_entry.last;
    assign m_err     = rd_entry.err;

    lval_sync_fifo_fwft #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk_rxg),
        .rst_n   (rst_rx_n),
        .wr_en   (wr_en),
        .wr_data (wr_entry),
        .rd_en   (rd_en),
        .rd_data (rd_entry),
        .full    (full),
        .empty   (empty)
    );

endmodule

// File: tb/tb_lval_line_packer.sv
// Scenario bench for lval_line_packer: randomized pixels and handshakes against a line-level model.
module tb_lval_line_packer;

    typedef logic [66:0] ent_t;

    logic        clk_rxg = 1'b0;
    logic        rst_rx_n;
    logic        sync_valid;
    logic [11:0] sync_data;
    logic        m_valid;
    logic        m_ready;
    logic [63:0] m_data;
    logic        m_first;
    logic        m_last;
    logic        m_err;
    logic        line_done;
    logic [15:0] line_cnt;
    logic [15:0] drop_cnt;
    logic        ovf_sticky;
    logic        sts_clr;

    int checks = 0;
    int failures = 0;
    int done_seen = 0;
    int clr_hits = 0;
    bit clr_on_done = 1'b0;
    int exp_line = 0;
    int exp_drop = 0;

    logic [11:0] pix [256];
    ent_t        got [$];
    ent_t        exp_q [$];

    always #5 clk_rxg = ~clk_rxg;

    lval_line_packer #(
        .LINE_PIXELS  (256),
        .PIX_PER_WORD (4),
        .FIFO_DEPTH   (16)
    ) dut (
        .clk_rxg    (clk_rxg),
        .rst_rx_n   (rst_rx_n),
        .sync_valid (sync_valid),
        .sync_data  (sync_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_first    (m_first),
        .m_last     (m_last),
        .m_err      (m_err),
        .line_done  (line_done),
        .line_cnt   (line_cnt),
        .drop_cnt   (drop_cnt),
        .ovf_sticky (ovf_sticky),
        .sts_clr    (sts_clr)
    );

    always @(negedge clk_rxg) begin
        if (rst_rx_n) begin
            if (m_valid && m_ready) got.push_back({m_err, m_last, m_first, m_data});
            if (line_done) begin
                done_seen++;
                if (sts_clr) clr_hits++;
            end
        end
    end

    // Line-level model: the first `keep` words of the current line, then an optional terminator.
    task automatic model_append(input int keep, input bit trunc);
        for (int w = 0; w < keep; w++) begin
            exp_q.push_back({1'b0, (w == 63), (w == 0),
                             4'b0, pix[4*w+3], 4'b0, pix[4*w+2], 4'b0, pix[4*w+1], 4'b0, pix[4*w]});
        end
        if (trunc) exp_q.push_back({1'b1, 1'b1, 1'b0, 64'h0});
    endtask

    task automatic fill_pix(input bit rnd);
        for (int i = 0; i < 256; i++) pix[i] = rnd ? 12'($urandom) : 12'(i);
    endtask

    task automatic cyc(input logic v, input logic [11:0] d, input logic r);
        @(posedge clk_rxg);
        #1;
        sync_valid = v;
        sync_data  = d;
        m_ready    = r;
        #1;
        sts_clr = clr_on_done && line_done;
    endtask

    task automatic idle(input int n, input logic r);
        repeat (n) cyc(1'b0, 12'h0, r);
    endtask

    // gap: drop every third cycle plus random holes; rdy: 0 always ready, 1 random, 2 never
    task automatic send_line(input bit gap, input int rdy);
        int sent = 0;
        int c = 0;
        logic v, r;
        while (sent < 256 && c < 5000) begin
            v = gap ? ((c % 3 != 2) && ($urandom % 4 != 0)) : 1'b1;
            r = (rdy == 0) ? 1'b1 : (rdy == 1) ? 1'($urandom) : 1'b0;
            cyc(v, v ? pix[sent] : 12'h0, r);
            if (v) sent++;
            c++;
        end
    endtask

    task automatic start_scenario();
        got.delete();
        exp_q.delete();
        done_seen = 0;
        clr_hits = 0;
    endtask

    task automatic test_reset();
        rst_rx_n = 1'b0;
        sync_valid = 1'b0;
        sync_data = '0;
        m_ready = 1'b0;
        sts_clr = 1'b0;
        repeat (3) @(posedge clk_rxg);
        #1;
        checks++;
        if ({m_valid, m_data, m_first, m_last, m_err, line_done, line_cnt, drop_cnt, ovf_sticky} !== '0) begin
            failures++;
            $display("FAIL reset_hold: got valid=%b data=%h lc=%h dc=%h ovf=%b exp all zero",
                     m_valid, m_data, line_cnt, drop_cnt, ovf_sticky);
        end
        rst_rx_n = 1'b1;
        idle(2, 1'b1);
        checks++;
        if ({m_valid, line_done, line_cnt, drop_cnt, ovf_sticky} !== '0) begin
            failures++;
            $display("FAIL reset_release: got valid=%b done=%b lc=%h dc=%h ovf=%b exp all zero",
                     m_valid, line_done, line_cnt, drop_cnt, ovf_sticky);
        end
    endtask

    task automatic test_basic_line();
        start_scenario();
        fill_pix(1'b0);
        model_append(64, 1'b0);
        send_line(1'b0, 0);
        idle(20, 1'b1);
        exp_line++;
        checks++;
        if (got.size() != exp_q.size()) begin
            failures++;
            $display("FAIL basic_count: got %0d words exp %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL basic_word%0d: got %h exp %h", i, got[i], exp_q[i]);
            end
        end
        if (got.size() > 0) begin
            checks++;
            if (got[0] !== {3'b001, 64'h0003_0002_0001_0000}) begin
                failures++;
                $display("FAIL basic_word0_const: got %h exp %h", got[0], {3'b001, 64'h0003_0002_0001_0000});
            end
        end
        checks++;
        if (done_seen != 1) begin
            failures++;
            $display("FAIL basic_line_done: got %0d pulses exp 1", done_seen);
        end
        checks++;
        if (line_cnt !== 16'(exp_line) || ovf_sticky !== 1'b0) begin
            failures++;
            $display("FAIL basic_status: got lc=%0d ovf=%b exp lc=%0d ovf=0", line_cnt, ovf_sticky, exp_line);
        end
    endtask

    task automatic test_gapped_random();
        start_scenario();
        fill_pix(1'b1);
        model_append(64, 1'b0);
        send_line(1'b1, 1);
        idle(80, 1'b1);
        exp_line++;
        checks++;
        if (got.size() != exp_q.size()) begin
            failures++;
            $display("FAIL gapped_count: got %0d words exp %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL gapped_word%0d: got %h exp %h", i, got[i], exp_q[i]);
            end
        end
        checks++;
        if (line_cnt !== 16'(exp_line) || ovf_sticky !== 1'b0 || done_seen != 1) begin
            failures++;
            $display("FAIL gapped_status: got lc=%0d ovf=%b done=%0d exp lc=%0d ovf=0 done=1",
                     line_cnt, ovf_sticky, done_seen, exp_line);
        end
    endtask

    task automatic test_overflow();
        start_scenario();
        fill_pix(1'b1);
        model_append(16, 1'b1);
        send_line(1'b0, 2);
        idle(5, 1'b0);
        checks++;
        if (got.size() != 0 || m_valid !== 1'b1 || ovf_sticky !== 1'b1) begin
            failures++;
            $display("FAIL ovf_hold: got words=%0d valid=%b ovf=%b exp words=0 valid=1 ovf=1",
                     got.size(), m_valid, ovf_sticky);
        end
        idle(60, 1'b1);
        exp_drop++;
        checks++;
        if (got.size() != exp_q.size()) begin
            failures++;
            $display("FAIL ovf_count: got %0d words exp %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL ovf_word%0d: got %h exp %h", i, got[i], exp_q[i]);
            end
        end
        checks++;
        if (drop_cnt !== 16'(exp_drop) || line_cnt !== 16'(exp_line) || done_seen != 1) begin
            failures++;
            $display("FAIL ovf_status: got dc=%0d lc=%0d done=%0d exp dc=%0d lc=%0d done=1",
                     drop_cnt, line_cnt, done_seen, exp_drop, exp_line);
        end
    endtask

    task automatic test_back_to_back();
        int n_err = 0;
        start_scenario();
        fill_pix(1'b1);
        model_append(16, 1'b1);
        exp_q.push_back({1'b1, 1'b1, 1'b0, 64'h0});
        for (int i = 0; i < 256; i++) cyc(1'b1, pix[i], 1'b0);
        fill_pix(1'b1);
        for (int i = 0; i < 256; i++) cyc(1'b1, pix[i], (i >= 10));
        idle(80, 1'b1);
        exp_drop += 2;
        foreach (got[i]) if (got[i][66]) n_err++;
        checks++;
        if (n_err != 2) begin
            failures++;
            $display("FAIL b2b_terminators: got %0d exp 2", n_err);
        end
        checks++;
        if (got.size() != exp_q.size()) begin
            failures++;
            $display("FAIL b2b_count: got %0d words exp %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL b2b_word%0d: got %h exp %h", i, got[i], exp_q[i]);
            end
        end
        checks++;
        if (drop_cnt !== 16'(exp_drop) || line_cnt !== 16'(exp_line) || ovf_sticky !== 1'b1) begin
            failures++;
            $display("FAIL b2b_status: got dc=%0d lc=%0d ovf=%b exp dc=%0d lc=%0d ovf=1",
                     drop_cnt, line_cnt, ovf_sticky, exp_drop, exp_line);
        end
    endtask

    task automatic test_clr_on_done();
        start_scenario();
        fill_pix(1'b1);
        model_append(64, 1'b0);
        clr_on_done = 1'b1;
        send_line(1'b0, 0);
        idle(20, 1'b1);
        clr_on_done = 1'b0;
        sts_clr = 1'b0;
        exp_line = 0;
        exp_drop = 0;
        checks++;
        if (clr_hits != 1) begin
            failures++;
            $display("FAIL clr_coincide: got %0d clear-on-done cycles exp 1", clr_hits);
        end
        checks++;
        if (line_cnt !== 16'd0 || drop_cnt !== 16'd0 || ovf_sticky !== 1'b0) begin
            failures++;
            $display("FAIL clr_status: got lc=%0d dc=%0d ovf=%b exp 0 0 0", line_cnt, drop_cnt, ovf_sticky);
        end
        checks++;
        if (got.size() != exp_q.size()) begin
            failures++;
            $display("FAIL clr_count: got %0d words exp %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL clr_word%0d: got %h exp %h", i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_midline();
        start_scenario();
        fill_pix(1'b1);
        for (int i = 0; i < 100; i++) cyc(1'b1, pix[i], 1'b0);
        @(posedge clk_rxg);
        #1;
        sync_valid = 1'b0;
        checks++;
        if (m_valid !== 1'b1 || ovf_sticky !== 1'b1) begin
            failures++;
            $display("FAIL midreset_pre: got valid=%b ovf=%b exp 1 1", m_valid, ovf_sticky);
        end
        rst_rx_n = 1'b0;
        #1;
        exp_line = 0;
        exp_drop = 0;
        checks++;
        if (m_valid !== 1'b0 || ovf_sticky !== 1'b0 || line_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
            failures++;
            $display("FAIL midreset_async: got valid=%b ovf=%b lc=%0d dc=%0d exp all 0",
                     m_valid, ovf_sticky, line_cnt, drop_cnt);
        end
        idle(2, 1'b0);
        rst_rx_n = 1'b1;
        start_scenario();
        fill_pix(1'b1);
        model_append(64, 1'b0);
        send_line(1'b1, 1);
        idle(80, 1'b1);
        exp_line = 1;
        checks++;
        if (got.size() != exp_q.size()) begin
            failures++;
            $display("FAIL midreset_count: got %0d words exp %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL midreset_word%0d: got %h exp %h", i, got[i], exp_q[i]);
            end
        end
        checks++;
        if (line_cnt !== 16'(exp_line) || ovf_sticky !== 1'b0) begin
            failures++;
            $display("FAIL midreset_status: got lc=%0d ovf=%b exp lc=%0d ovf=0", line_cnt, ovf_sticky, exp_line);
        end
    endtask

    initial begin
        test_reset();
        test_basic_line();
        test_gapped_random();
        test_overflow();
        test_back_to_back();
        test_clr_on_done();
        test_reset_midline();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
